// File: rtl/rsa_result_streamer.sv
// rsa_result_streamer
// Captures the full modular-exponentiation result from the MonPro core in one
// parallel transfer, then streams it to the host as DATA_WIDTH-bit words over
// a valid/ready handshake, least-significant word first (the same order in
// which operands are loaded into the core).

module rsa_result_streamer #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            res_valid_i,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] res_data_i,
    output logic                            res_ready_o,
    input  logic                            get_result_i,
    output logic                            out_valid_o,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    input  logic                            out_ready_i,
    output logic                            out_last_o,
    output logic [CNT_WIDTH-1:0]            word_idx_o,
    output logic                            busy_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        STREAM
    } state_e;

    state_e                 state_q, state_d;

    // The stored result is kept as an array of words so the streamed word
    // can be selected directly by the word index.
    logic [DATA_WIDTH-1:0]  result_q [NUM_WORDS];
    logic                   capture;

    logic [CNT_WIDTH-1:0]   word_idx_q, word_idx_d;
    logic [CNT_WIDTH-1:0]   next_idx;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;

    logic                   handshake;
    logic                   at_last;

    assign handshake = out_valid_q && out_ready_i;
    assign at_last   = (word_idx_q == LAST_IDX);
    assign next_idx  = word_idx_q + CNT_WIDTH'(1);

    // State register; reset returns the block to IDLE from any state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture in IDLE, start on getResult in LOADED,
    // return to IDLE once the last word has been accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (res_valid_i) begin
                    state_d = LOADED;
                end
            end
            LOADED: begin
                if (get_result_i) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (handshake && at_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output/datapath next values; all streamed outputs are registered so
    // out_ready only ever reaches out_data through a flop.
    always_comb begin
        capture     = 1'b0;
        word_idx_d  = word_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                capture     = res_valid_i;
                word_idx_d  = '0;
                out_data_d  = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
            LOADED: begin
                if (get_result_i) begin
                    word_idx_d  = '0;
                    out_data_d  = result_q[0];
                    out_valid_d = 1'b1;
                    out_last_d  = (LAST_IDX == '0);
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (at_last) begin
                        word_idx_d  = '0;
                        out_data_d  = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        word_idx_d  = next_idx;
                        out_data_d  = result_q[next_idx];
                        out_valid_d = 1'b1;
                        out_last_d  = (next_idx == LAST_IDX);
                    end
                end
            end
            default: begin
                word_idx_d  = '0;
                out_data_d  = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // Result register: loaded in a single transfer, cleared by reset so a
    // reset discards any stored result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                result_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                result_q[i] <= res_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Streamed-word registers: index, data, valid and last flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_idx_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            word_idx_q  <= word_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign res_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign word_idx_o  = word_idx_q;

endmodule

// File: tb/tb_rsa_result_streamer.sv
// Self-checking bench for rsa_result_streamer: a directed vector table for the
// basic stream, hand-written sequences for backpressure, ignored inputs,
// mid-stream reset and back-to-back results, and a randomized run checked
// against a transaction-level reference model.

module tb_rsa_result_streamer;

    localparam int DW = 64;
    localparam int NW = 16;
    localparam int CW = 4;

    logic              clk;
    logic              rst_n;
    logic              resValid;
    logic [DW*NW-1:0]  resData;
    logic              resReady;
    logic              getResult;
    logic              outValid;
    logic [DW-1:0]     outData;
    logic              outReady;
    logic              outLast;
    logic [CW-1:0]     wordIdx;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          resValid;
        logic          getRes;
        logic          outReady;
        logic          expResReady;
        logic          expBusy;
        logic          expValid;
        logic          expLast;
        logic [CW-1:0] expIdx;
        logic [DW-1:0] expData;
    } vec_t;

    vec_t vecs[NW+2];

    rsa_result_streamer #(
        .DATA_WIDTH(DW),
        .NUM_WORDS (NW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .res_valid_i (resValid),
        .res_data_i  (resData),
        .res_ready_o (resReady),
        .get_result_i(getResult),
        .out_valid_o (outValid),
        .out_data_o  (outData),
        .out_ready_i (outReady),
        .out_last_o  (outLast),
        .word_idx_o  (wordIdx),
        .busy_o      (busy)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word i of the basic pattern is the nibble i repeated across the word.
    function automatic logic [DW-1:0] nibbleWord(int i);
        logic [3:0] n;
        n = 4'(i);
        return {16{n}};
    endfunction

    function automatic logic [DW*NW-1:0] nibblePattern();
        logic [DW*NW-1:0] p;
        for (int i = 0; i < NW; i++) p[i*DW +: DW] = nibbleWord(i);
        return p;
    endfunction

    function automatic logic [DW*NW-1:0] uniformPattern(logic [DW-1:0] w);
        logic [DW*NW-1:0] p;
        for (int i = 0; i < NW; i++) p[i*DW +: DW] = w;
        return p;
    endfunction

    function automatic logic [DW*NW-1:0] randomPattern();
        logic [DW*NW-1:0] p;
        for (int i = 0; i < NW; i++) p[i*DW +: DW] = {$urandom(), $urandom()};
        return p;
    endfunction

    task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(logic rv, logic [DW*NW-1:0] data, logic gr, logic ordy);
        resValid  = rv;
        resData   = data;
        getResult = gr;
        outReady  = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(string tag);
        checkOutput({tag, "_res_ready"}, 64'(resReady), 64'd1);
        checkOutput({tag, "_busy"},      64'(busy),     64'd0);
        checkOutput({tag, "_out_valid"}, 64'(outValid), 64'd0);
        checkOutput({tag, "_word_idx"},  64'(wordIdx),  64'd0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    // Capture a pattern from IDLE and start the stream; returns with word 0 shown.
    task automatic captureAndStart(logic [DW*NW-1:0] pat);
        applyStimulus(1'b1, pat, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Accept words until out_valid drops, checking each against the pattern;
    // optional spurious res_valid/getResult traffic is applied meanwhile.
    task automatic drainStream(string tag, logic [DW*NW-1:0] pat, logic spur,
                               logic [DW*NW-1:0] spurData);
        int n;
        n = 0;
        for (int c = 0; c < 40 && outValid === 1'b1; c++) begin
            checkOutput({tag, "_data"}, outData, pat[n*DW +: DW]);
            checkOutput({tag, "_idx"}, 64'(wordIdx), 64'(n));
            checkOutput({tag, "_last"}, 64'(outLast), 64'(n == NW-1));
            checkOutput({tag, "_res_ready"}, 64'(resReady), 64'd0);
            n++;
            applyStimulus(spur, spurData, spur, 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput({tag, "_count"}, 64'(n), 64'(NW));
    endtask

    // Reference model state, expressed as a stored word list and a queue of
    // words still owed to the host.
    localparam int M_IDLE = 0, M_LOADED = 1, M_STREAM = 2;
    int            mPhase;
    logic [DW-1:0] mStored [NW];
    logic [DW-1:0] mQueue [$];

    task automatic runRandom(int cycles);
        logic             rv, gr, ordy;
        logic [DW*NW-1:0] data;
        mPhase = M_IDLE;
        mQueue.delete();
        for (int c = 0; c < cycles; c++) begin
            rv   = ($urandom_range(0, 3) == 0);
            gr   = ($urandom_range(0, 2) == 0);
            ordy = ($urandom_range(0, 9) < 7);
            data = randomPattern();
            applyStimulus(rv, data, gr, ordy);
            case (mPhase)
                M_IDLE: if (rv) begin
                    for (int i = 0; i < NW; i++) mStored[i] = data[i*DW +: DW];
                    mPhase = M_LOADED;
                end
                M_LOADED: if (gr) begin
                    for (int i = 0; i < NW; i++) mQueue.push_back(mStored[i]);
                    mPhase = M_STREAM;
                end
                default: if (ordy) begin
                    void'(mQueue.pop_front());
                    if (mQueue.size() == 0) mPhase = M_IDLE;
                end
            endcase
            tick();
            checkOutput("rnd_res_ready", 64'(resReady), 64'(mPhase == M_IDLE));
            checkOutput("rnd_busy", 64'(busy), 64'(mPhase != M_IDLE));
            checkOutput("rnd_out_valid", 64'(outValid), 64'(mPhase == M_STREAM));
            if (mPhase == M_STREAM) begin
                checkOutput("rnd_data", outData, mQueue[0]);
                checkOutput("rnd_last", 64'(outLast), 64'(mQueue.size() == 1));
                checkOutput("rnd_idx", 64'(wordIdx), 64'(NW - mQueue.size()));
            end else begin
                checkOutput("rnd_last", 64'(outLast), 64'd0);
                checkOutput("rnd_idx", 64'(wordIdx), 64'd0);
            end
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int validCycles;
        logic [DW*NW-1:0] patA;
        logic [DW*NW-1:0] patB;

        patA = nibblePattern();
        patB = uniformPattern(64'hDEADBEEFCAFEF00D);

        // Reset values while reset is held.
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #1;
        checkIdle("reset");
        checkOutput("reset_out_data", outData, 64'd0);
        checkOutput("reset_out_last", 64'(outLast), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Directed table: capture, start, then 16 accepted words.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, nibbleWord(0)};
        for (int i = 1; i < NW; i++) begin
            vecs[i+1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, (i == NW-1),
                          CW'(i), nibbleWord(i)};
        end
        vecs[NW+1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0};
        for (int v = 0; v < NW+2; v++) begin
            applyStimulus(vecs[v].resValid, patA, vecs[v].getRes, vecs[v].outReady);
            tick();
            checkOutput("tbl_res_ready", 64'(resReady), 64'(vecs[v].expResReady));
            checkOutput("tbl_busy", 64'(busy), 64'(vecs[v].expBusy));
            checkOutput("tbl_out_valid", 64'(outValid), 64'(vecs[v].expValid));
            checkOutput("tbl_out_last", 64'(outLast), 64'(vecs[v].expLast));
            checkOutput("tbl_word_idx", 64'(wordIdx), 64'(vecs[v].expIdx));
            if (vecs[v].expValid) checkOutput("tbl_out_data", outData, vecs[v].expData);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Backpressure: stall 3 cycles while word 5 is presented.
        captureAndStart(patA);
        validCycles = 0;
        for (int k = 0; k < 5; k++) begin
            if (outValid) validCycles++;
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            tick();
        end
        checkOutput("bp_idx_before", 64'(wordIdx), 64'd5);
        for (int k = 0; k < 3; k++) begin
            if (outValid) validCycles++;
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            tick();
            checkOutput("bp_hold_data", outData, 64'h5555555555555555);
            checkOutput("bp_hold_valid", 64'(outValid), 64'd1);
            checkOutput("bp_hold_idx", 64'(wordIdx), 64'd5);
            checkOutput("bp_hold_last", 64'(outLast), 64'd0);
        end
        if (outValid) validCycles++;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("bp_resume_idx", 64'(wordIdx), 64'd6);
        checkOutput("bp_resume_data", outData, 64'h6666666666666666);
        for (int c = 0; c < 40 && outValid === 1'b1; c++) begin
            validCycles++;
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("bp_total_cycles", 64'(validCycles), 64'd19);
        checkIdle("bp_end");

        // Ignored inputs: getResult in IDLE does nothing.
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        repeat (3) begin
            tick();
            checkOutput("ign_idle_valid", 64'(outValid), 64'd0);
            checkOutput("ign_idle_busy", 64'(busy), 64'd0);
        end
        // res_valid with another pattern in LOADED and during STREAM.
        applyStimulus(1'b1, patA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, patB, 1'b0, 1'b0);
        tick();
        checkOutput("ign_loaded_res_ready", 64'(resReady), 64'd0);
        checkOutput("ign_loaded_valid", 64'(outValid), 64'd0);
        applyStimulus(1'b1, patB, 1'b1, 1'b0);
        tick();
        drainStream("ign_stream", patA, 1'b1, patB);
        checkIdle("ign_end");

        // Reset asserted while word 7 is presented.
        captureAndStart(patA);
        for (int c = 0; c < 20 && wordIdx != 4'd7; c++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("rst_pre_idx", 64'(wordIdx), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", 64'(outValid), 64'd0);
        checkOutput("rst_async_data", outData, 64'd0);
        checkOutput("rst_async_idx", 64'(wordIdx), 64'd0);
        checkOutput("rst_async_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checkIdle("rst_after");
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        repeat (2) begin
            tick();
            checkOutput("rst_no_partial", 64'(outValid), 64'd0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Back-to-back: new capture on the cycle after the last handshake.
        captureAndStart(patA);
        drainStream("b2b_first", patA, 1'b0, '0);
        checkOutput("b2b_gap_res_ready", 64'(resReady), 64'd1);
        captureAndStart(uniformPattern(64'hEAA06C6A1B82DFBB));
        drainStream("b2b_second", uniformPattern(64'hEAA06C6A1B82DFBB), 1'b0, '0);
        checkIdle("b2b_end");

        // Randomized traffic against the reference model.
        doReset();
        runRandom(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
